spi_packet_sched: RTL and testbench
===================================

Name: spi_packet_sched

Overview:
Round-robin scheduler sharing one spi_packet_tx engine between NUM_CH requesters. Each requester posts a packet descriptor (addr, length, id, type) plus a 32-bit payload stream. The block arbitrates, pre-screens the length, and drives the engine's config inputs and tx_enable. It muxes the winner's payload into the engine and reports one completion record per descriptor.

Parameters:
NUM_CH, 4, number of requesters (2..8)
START_TIMEOUT, 1024, cycles allowed in RUN with pkt_sending low before abort

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
sched_enable  in  1  permit new arbitration
req_valid  in  NUM_CH  descriptor valid per channel
req_ready  out  NUM_CH  descriptor accepted (one-hot pulse)
req_addr  in  NUM_CH*32  base address per channel
req_len  in  NUM_CH*32  byte length per channel
req_id  in  NUM_CH*16  packet id per channel
req_type  in  NUM_CH*16  packet type per channel
ch_data  in  NUM_CH*32  payload words
ch_data_valid  in  NUM_CH  payload valid
ch_data_ready  out  NUM_CH  payload accepted
pkt_base_addr/pkt_length  out  32 each  to engine tx_base_addr/tx_length
pkt_id/pkt_type  out  16 each  to engine tx_id/tx_packet_type
pkt_enable  out  1  to engine tx_enable
pkt_data  out  32  to engine data_in
pkt_data_valid  out  1  to engine data_in_valid
pkt_data_ready  in  1  from engine data_in_ready
pkt_end  in  1  from engine tx_data_end
pkt_error  in  1  from engine error
pkt_sending  in  1  from engine sending
done_valid  out  1  completion record valid
done_ready  in  1  completion accepted
done_ch  out  3  channel of completed descriptor
done_status  out  2  00 OK, 01 LEN_ERR, 10 TX_ERR, 11 TIMEOUT
busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer 0; config registers 0.
- States: IDLE, LOAD, RUN, REPORT.
- IDLE: pkt_enable=0. When sched_enable and any req_valid, grant the first valid channel at or after rr pointer (wrapping). In the same cycle: pulse req_ready[g]; latch the descriptor into config registers; latch done_ch=g; set rr pointer to (g+1) mod NUM_CH. Next state: LEN_ERR check first, otherwise LOAD.
- LEN_ERR check: latched length is 0 or length[1:0]!=0 -> REPORT with status LEN_ERR. The engine is never enabled.
- LOAD: pkt_enable=1 for exactly one cycle, with config stable. Then go to RUN.
- LOAD/RUN: pkt_enable=1. pkt_data=ch_data[g]. pkt_data_valid=ch_data_valid[g]. ch_data_ready[i]=(i==g)&&pkt_data_ready; 0 for other channels and in other states.
- RUN exit, in priority order:
  - pkt_end -> REPORT OK.
  - pkt_error -> REPORT TX_ERR.
  - Start counter reaches START_TIMEOUT-1 -> REPORT TIMEOUT.
- Start counter: counts while pkt_sending=0; clears whenever pkt_sending=1.
- Config outputs hold latched values until the next grant; they do not change during a packet.
- REPORT: pkt_enable=0, which forces the engine idle and cleans up after an error or timeout. done_valid=1 held until done_ready; then IDLE. At most one outstanding completion.
- sched_enable falling mid-packet: current packet completes normally; no new grant until it rises.
- A channel dropping req_valid after the grant has no effect; the descriptor is already latched.
- Simultaneous pkt_end and pkt_error in RUN: OK wins.
- Reset mid-packet: immediate return to IDLE with outputs zeroed; no completion record issued.
- Latency: grant to pkt_enable = 1 cycle; pkt_end to done_valid = 1 cycle.

Optional Feature:
SPI_SCHED_STATS_EN
- Defined: adds input stats_clr and outputs ok_cnt and err_cnt (NUM_CH*16 each). These are per-channel 16-bit saturating counters. ok_cnt increments on OK; err_cnt increments on LEN_ERR, TX_ERR or TIMEOUT, at REPORT entry. stats_clr zeroes all counters; if coincident with an increment, clear wins.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package spi_sched_pkg holds:
  - sched_state_t enum
  - done_status_t enum (STAT_OK, STAT_LEN_ERR, STAT_TX_ERR, STAT_TIMEOUT)
  - START_TIMEOUT default
  - word-size constant 4
- Sub-module rr_arbiter (NUM_CH request vector plus pointer in; one-hot grant and index out) is natural and reusable.

Test Plan:
- Ch1 only, len=8, engine model accepts 2 words then pkt_end -> req_ready[1] pulse; pkt_enable high through RUN; done_ch=1, status=00.
- All 4 channels valid, pointer=0, 4 back-to-back packets -> grant order 0,1,2,3, then pointer=0; done_ch sequence matches.
- Ch2 len=6 -> LEN_ERR. pkt_enable never asserted; done_status=01 one cycle after grant.
- Ch0 never asserts ch_data_valid, START_TIMEOUT=16 -> status=11 after 16 RUN cycles; pkt_enable low in REPORT.
- pkt_error pulse mid-payload -> status=10. With done_ready held low for 5 cycles, done_valid stays high and no new grant occurs.
- rst_n asserted mid-RUN -> all outputs 0 immediately. After release, rr pointer 0, and the next grant goes to the lowest valid channel.

Source files
------------

// File: rtl/spi_sched_pkg.sv
// Shared types and constants for the spi_packet_sched scheduler slice.
package spi_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_RUN    = 2'd2,
    S_REPORT = 2'd3
  } sched_state_t;

  typedef enum logic [1:0] {
    STAT_OK      = 2'b00,
    STAT_LEN_ERR = 2'b01,
    STAT_TX_ERR  = 2'b10,
    STAT_TIMEOUT = 2'b11
  } done_status_t;

  localparam int unsigned START_TIMEOUT_DEF = 1024;
  localparam int unsigned WORD_BYTES        = 4;

  // The engine moves whole 32-bit words, so a length must be a non-zero multiple of 4.
  function automatic logic len_is_bad(input logic [31:0] len);
    return (len == 32'd0) || ((len & 32'(WORD_BYTES - 1)) != 32'd0);
  endfunction

endpackage

// File: rtl/spi_packet_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  localparam int CW = IDX_W + 1;

  logic [CW-1:0] cand;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(NUM_CH)) cand = cand - CW'(NUM_CH);
      if (!any && req[cand[IDX_W-1:0]]) begin
        any                 = 1'b1;
        gnt[cand[IDX_W-1:0]] = 1'b1;
        idx                 = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/spi_packet_sched.sv
// Round-robin scheduler sharing one spi_packet_tx engine between NUM_CH requesters.
// Optional per-channel statistics counters enabled with `define SPI_SCHED_STATS_EN.
module spi_packet_sched
  import spi_sched_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef SPI_SCHED_STATS_EN
  input  logic                 stats_clr,
  output logic [NUM_CH*16-1:0] ok_cnt,
  output logic [NUM_CH*16-1:0] err_cnt,
`endif
  input  logic                 sched_enable,
  input  logic [NUM_CH-1:0]    req_valid,
  output logic [NUM_CH-1:0]    req_ready,
  input  logic [NUM_CH*32-1:0] req_addr,
  input  logic [NUM_CH*32-1:0] req_len,
  input  logic [NUM_CH*16-1:0] req_id,
  input  logic [NUM_CH*16-1:0] req_type,
  input  logic [NUM_CH*32-1:0] ch_data,
  input  logic [NUM_CH-1:0]    ch_data_valid,
  output logic [NUM_CH-1:0]    ch_data_ready,
  output logic [31:0]          pkt_base_addr,
  output logic [31:0]          pkt_length,
  output logic [15:0]          pkt_id,
  output logic [15:0]          pkt_type,
  output logic                 pkt_enable,
  output logic [31:0]          pkt_data,
  output logic                 pkt_data_valid,
  input  logic                 pkt_data_ready,
  input  logic                 pkt_end,
  input  logic                 pkt_error,
  input  logic                 pkt_sending,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic [2:0]           done_ch,
  output logic [1:0]           done_status,
  output logic                 busy
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(START_TIMEOUT) + 1;

  sched_state_t     state, state_nxt;
  done_status_t     status_r, status_nxt;
  logic [IDX_W-1:0] rr_ptr, gnt_idx, arb_idx;
  logic [NUM_CH-1:0] arb_gnt;
  logic             arb_any, grant_go, active, timeout_hit, len_bad;
  logic [CNT_W-1:0] start_cnt;
  logic [31:0]      sel_addr, sel_len;
  logic [15:0]      sel_id, sel_type;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Gated by rst_n so req_ready stays low while reset is held, even with requests pending.
  assign grant_go  = rst_n && (state == S_IDLE) && sched_enable && arb_any;
  assign req_ready = grant_go ? arb_gnt : '0;

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    sel_id   = '0;
    sel_type = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_addr = req_addr[i*32 +: 32];
        sel_len  = req_len[i*32 +: 32];
        sel_id   = req_id[i*16 +: 16];
        sel_type = req_type[i*16 +: 16];
      end
    end
  end

  assign len_bad     = len_is_bad(sel_len);
  assign timeout_hit = !pkt_sending && (start_cnt == CNT_W'(START_TIMEOUT - 1));

  always_comb begin
    state_nxt  = state;
    status_nxt = status_r;
    case (state)
      S_IDLE: begin
        if (grant_go) begin
          if (len_bad) begin
            state_nxt  = S_REPORT;
            status_nxt = STAT_LEN_ERR;
          end else begin
            state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: state_nxt = S_RUN;
      S_RUN: begin
        // pkt_end outranks pkt_error when both arrive together.
        if (pkt_end) begin
          state_nxt  = S_REPORT;
          status_nxt = STAT_OK;
        end else if (pkt_error) begin
          state_nxt  = S_REPORT;
          status_nxt = STAT_TX_ERR;
        end else if (timeout_hit) begin
          state_nxt  = S_REPORT;
          status_nxt = STAT_TIMEOUT;
        end
      end
      S_REPORT: if (done_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      status_r      <= STAT_OK;
      rr_ptr        <= '0;
      gnt_idx       <= '0;
      done_ch       <= '0;
      pkt_base_addr <= '0;
      pkt_length    <= '0;
      pkt_id        <= '0;
      pkt_type      <= '0;
      start_cnt     <= '0;
    end else begin
      state    <= state_nxt;
      status_r <= status_nxt;
      if (grant_go) begin
        gnt_idx       <= arb_idx;
        done_ch       <= 3'(arb_idx);
        pkt_base_addr <= sel_addr;
        pkt_length    <= sel_len;
        pkt_id        <= sel_id;
        pkt_type      <= sel_type;
        rr_ptr        <= (arb_idx == IDX_W'(NUM_CH - 1)) ? '0 : arb_idx + 1'b1;
      end
      if ((state == S_RUN) && !pkt_sending) start_cnt <= start_cnt + 1'b1;
      else                                  start_cnt <= '0;
    end
  end

  assign active      = (state == S_LOAD) || (state == S_RUN);
  assign pkt_enable  = active;
  assign done_valid  = (state == S_REPORT);
  assign done_status = status_r;
  assign busy        = (state != S_IDLE);

  always_comb begin
    pkt_data       = '0;
    pkt_data_valid = 1'b0;
    ch_data_ready  = '0;
    if (active) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (gnt_idx == IDX_W'(i)) begin
          pkt_data         = ch_data[i*32 +: 32];
          pkt_data_valid   = ch_data_valid[i];
          ch_data_ready[i] = pkt_data_ready;
        end
      end
    end
  end

`ifdef SPI_SCHED_STATS_EN
  logic             report_entry;
  logic [IDX_W-1:0] entry_ch;
  logic [15:0]      ok_r  [NUM_CH];
  logic [15:0]      err_r [NUM_CH];

  assign report_entry = (state_nxt == S_REPORT) && (state != S_REPORT);
  // A LEN_ERR report leaves IDLE before gnt_idx is written, so take the arbiter's index then.
  assign entry_ch     = (state == S_IDLE) ? arb_idx : gnt_idx;

  // NOTE: these counters are architectural state, so unlike a RAM array every entry is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ok_r[i]  <= '0;
        err_r[i] <= '0;
      end
    end else if (stats_clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ok_r[i]  <= '0;
        err_r[i] <= '0;
      end
    end else if (report_entry) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (entry_ch == IDX_W'(i)) begin
          if (status_nxt == STAT_OK) begin
            if (ok_r[i] != 16'hFFFF) ok_r[i] <= ok_r[i] + 16'd1;
          end else begin
            if (err_r[i] != 16'hFFFF) err_r[i] <= err_r[i] + 16'd1;
          end
        end
      end
    end
  end

  always_comb begin
    ok_cnt  = '0;
    err_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ok_cnt[i*16 +: 16]  = ok_r[i];
      err_cnt[i*16 +: 16] = err_r[i];
    end
  end
`else
  // Default build carries no statistics counters.
`endif

endmodule

// File: tb/tb_spi_packet_sched.sv
// Directed self-checking bench for spi_packet_sched (NUM_CH=4, START_TIMEOUT=16).
module tb_spi_packet_sched;

  localparam int NUM_CH        = 4;
  localparam int START_TIMEOUT = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 sched_enable;
  logic [NUM_CH-1:0]    req_valid;
  logic [NUM_CH-1:0]    req_ready;
  logic [NUM_CH*32-1:0] req_addr;
  logic [NUM_CH*32-1:0] req_len;
  logic [NUM_CH*16-1:0] req_id;
  logic [NUM_CH*16-1:0] req_type;
  logic [NUM_CH*32-1:0] ch_data;
  logic [NUM_CH-1:0]    ch_data_valid;
  logic [NUM_CH-1:0]    ch_data_ready;
  logic [31:0]          pkt_base_addr, pkt_length, pkt_data;
  logic [15:0]          pkt_id, pkt_type;
  logic                 pkt_enable, pkt_data_valid, pkt_data_ready;
  logic                 pkt_end, pkt_error, pkt_sending;
  logic                 done_valid, done_ready, busy;
  logic [2:0]           done_ch;
  logic [1:0]           done_status;
`ifdef SPI_SCHED_STATS_EN
  logic                 stats_clr = 1'b0;
  logic [NUM_CH*16-1:0] ok_cnt, err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_packet_sched #(.NUM_CH(NUM_CH), .START_TIMEOUT(START_TIMEOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef SPI_SCHED_STATS_EN
    .stats_clr      (stats_clr),
    .ok_cnt         (ok_cnt),
    .err_cnt        (err_cnt),
`endif
    .sched_enable   (sched_enable),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_len        (req_len),
    .req_id         (req_id),
    .req_type       (req_type),
    .ch_data        (ch_data),
    .ch_data_valid  (ch_data_valid),
    .ch_data_ready  (ch_data_ready),
    .pkt_base_addr  (pkt_base_addr),
    .pkt_length     (pkt_length),
    .pkt_id         (pkt_id),
    .pkt_type       (pkt_type),
    .pkt_enable     (pkt_enable),
    .pkt_data       (pkt_data),
    .pkt_data_valid (pkt_data_valid),
    .pkt_data_ready (pkt_data_ready),
    .pkt_end        (pkt_end),
    .pkt_error      (pkt_error),
    .pkt_sending    (pkt_sending),
    .done_valid     (done_valid),
    .done_ready     (done_ready),
    .done_ch        (done_ch),
    .done_status    (done_status),
    .busy           (busy)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input int ch, input logic [31:0] addr, input logic [31:0] len,
                          input logic [15:0] id, input logic [15:0] ptype);
    req_addr[ch*32 +: 32] = addr;
    req_len[ch*32 +: 32]  = len;
    req_id[ch*16 +: 16]   = id;
    req_type[ch*16 +: 16] = ptype;
  endtask

  task automatic ack_done();
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; sched_enable = 1'b0; req_valid = '0;
    req_addr = '0; req_len = '0; req_id = '0; req_type = '0;
    ch_data = '0; ch_data_valid = '0; pkt_data_ready = 1'b0;
    pkt_end = 1'b0; pkt_error = 1'b0; pkt_sending = 1'b0; done_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_pkt_enable", pkt_enable, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done_valid", done_valid, 1'b0);
    check("rst_pkt_length", pkt_length, 32'd0);
    check("rst_done_status", done_status, 2'b00);
    rst_n = 1'b1;
    tick();

    // Channel 1 alone, len 8, two words then pkt_end
    set_desc(1, 32'h1000_0100, 32'd8, 16'h0011, 16'h0002);
    sched_enable = 1'b1;
    req_valid = 4'b0010;
    #1;
    check("t1_req_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    #1;
    check("t1_load_enable", pkt_enable, 1'b1);
    check("t1_req_ready_pulse", req_ready, 4'b0000);
    check("t1_base_addr", pkt_base_addr, 32'h1000_0100);
    check("t1_length", pkt_length, 32'd8);
    check("t1_id", pkt_id, 16'h0011);
    check("t1_type", pkt_type, 16'h0002);
    tick();
    pkt_data_ready = 1'b1; pkt_sending = 1'b1;
    ch_data[63:32] = 32'hA5A5_0001; ch_data_valid = 4'b0010;
    #1;
    check("t1_run_enable", pkt_enable, 1'b1);
    check("t1_data0", pkt_data, 32'hA5A5_0001);
    check("t1_data_valid", pkt_data_valid, 1'b1);
    check("t1_ch_ready", ch_data_ready, 4'b0010);
    tick();
    ch_data[63:32] = 32'hA5A5_0002;
    #1;
    check("t1_data1", pkt_data, 32'hA5A5_0002);
    tick();
    ch_data_valid = '0; pkt_end = 1'b1;
    #1;
    check("t1_still_run", done_valid, 1'b0);
    tick();
    pkt_end = 1'b0; pkt_sending = 1'b0;
    #1;
    check("t1_done_valid", done_valid, 1'b1);
    check("t1_done_ch", done_ch, 3'd1);
    check("t1_done_status", done_status, 2'b00);
    check("t1_report_enable", pkt_enable, 1'b0);
    check("t1_report_ch_ready", ch_data_ready, 4'b0000);
    ack_done();
    check("t1_idle_done_valid", done_valid, 1'b0);
    check("t1_idle_busy", busy, 1'b0);

    // Reset in the middle of a channel-3 packet (pointer is now 2)
    set_desc(3, 32'h3000_0000, 32'd16, 16'h0033, 16'h0001);
    req_valid = 4'b1000;
    #1;
    check("t6_req_ready", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    tick();
    ch_data_valid = 4'b1000;
    for (int i = 0; i < NUM_CH; i++)
      set_desc(i, 32'h2000_0000 + 32'(i) * 32'h100, 32'd4 * 32'(i + 1), 16'(16'h0100 + i), 16'h0005);
    req_valid = 4'b1111;
    #1;
    check("t6_run_busy", busy, 1'b1);
    check("t6_run_data_valid", pkt_data_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_enable", pkt_enable, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_req_ready", req_ready, 4'b0000);
    check("t6_rst_data_valid", pkt_data_valid, 1'b0);
    check("t6_rst_ch_ready", ch_data_ready, 4'b0000);
    check("t6_rst_length", pkt_length, 32'd0);
    check("t6_rst_id", pkt_id, 16'h0000);
    check("t6_rst_done_valid", done_valid, 1'b0);
    tick();
    rst_n = 1'b1; ch_data_valid = '0;
    #1;
    check("t6_post_rst_grant", req_ready, 4'b0001);

    // All four channels valid: grants 0,1,2,3 then back to 0
    for (int i = 0; i < NUM_CH; i++) begin
      check($sformatf("t2_grant%0d", i), req_ready, 32'(1) << i);
      tick();
      check($sformatf("t2_len%0d", i), pkt_length, 32'd4 * 32'(i + 1));
      tick();
      pkt_end = 1'b1;
      tick();
      pkt_end = 1'b0;
      check($sformatf("t2_done_ch%0d", i), done_ch, 3'(i));
      check($sformatf("t2_status%0d", i), done_status, 2'b00);
      ack_done();
    end
    check("t2_wrap_grant", req_ready, 4'b0001);
    req_valid = '0;
    #1;

    // Channel 2 with len 6: length error, engine never enabled
    set_desc(2, 32'h4000_0000, 32'd6, 16'h0042, 16'h0003);
    req_valid = 4'b0100;
    #1;
    check("t3_req_ready", req_ready, 4'b0100);
    check("t3_grant_enable", pkt_enable, 1'b0);
    tick();
    req_valid = '0;
    #1;
    check("t3_done_valid", done_valid, 1'b1);
    check("t3_status", done_status, 2'b01);
    check("t3_done_ch", done_ch, 3'd2);
    check("t3_enable", pkt_enable, 1'b0);
    ack_done();

    // Channel 3 with len 0: length error as well
    set_desc(3, 32'h5000_0000, 32'd0, 16'h0053, 16'h0003);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    #1;
    check("t3b_status", done_status, 2'b01);
    check("t3b_done_ch", done_ch, 3'd3);
    check("t3b_enable", pkt_enable, 1'b0);
    ack_done();

    // Channel 0 never supplies data and the engine never starts: timeout after 16 RUN cycles
    set_desc(0, 32'h6000_0000, 32'd16, 16'h0060, 16'h0004);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    #1;
    check("t4_load_enable", pkt_enable, 1'b1);
    tick();
    check("t4_data_valid", pkt_data_valid, 1'b0);
    check("t4_ch_ready", ch_data_ready, 4'b0001);
    repeat (15) tick();
    check("t4_still_run_enable", pkt_enable, 1'b1);
    check("t4_still_run_done", done_valid, 1'b0);
    tick();
    check("t4_done_valid", done_valid, 1'b1);
    check("t4_status", done_status, 2'b11);
    check("t4_done_ch", done_ch, 3'd0);
    check("t4_report_enable", pkt_enable, 1'b0);
    ack_done();

    // Channel 1 engine error mid-payload; completion held while done_ready stays low
    set_desc(1, 32'h7000_0000, 32'd12, 16'h0071, 16'h0006);
    set_desc(2, 32'h8000_0000, 32'd8, 16'h0082, 16'h0007);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    pkt_sending = 1'b1; ch_data_valid = 4'b0010;
    tick();
    pkt_error = 1'b1;
    tick();
    pkt_error = 1'b0; pkt_sending = 1'b0; ch_data_valid = '0;
    check("t5_status", done_status, 2'b10);
    check("t5_done_ch", done_ch, 3'd1);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("t5_hold_valid%0d", k), done_valid, 1'b1);
      check($sformatf("t5_hold_no_grant%0d", k), req_ready, 4'b0000);
      tick();
    end
    ack_done();
    check("t5_released", done_valid, 1'b0);
    check("t5_next_grant", req_ready, 4'b0100);

    // Channel 2: pkt_end and pkt_error together, OK wins
    tick();
    req_valid = '0;
    tick();
    pkt_end = 1'b1; pkt_error = 1'b1;
    tick();
    pkt_end = 1'b0; pkt_error = 1'b0;
    check("t7_status", done_status, 2'b00);
    check("t7_done_ch", done_ch, 3'd2);
    ack_done();
    check("t7_idle_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
